// File: rtl/dm_port_arb.sv
// Data-memory port arbiter: core M-stage has priority, DMA gets a forced grant after STARVE_MAX denied cycles.
// Optional macro DM_ARB_BURST_EN lets a forced grant run up to BURST_LEN consecutive DMA beats.
module dm_port_arb #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4,
   parameter int BURST_LEN  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            core_req,
   input  logic            core_wr,
   input  logic [AW-1:0]   core_addr,
   input  logic [DW-1:0]   core_wd,
   input  logic [DW/8-1:0] core_be,
   output logic [DW-1:0]   core_rd,
   output logic            core_stall,
   input  logic            dma_req,
   input  logic            dma_wr,
   input  logic [AW-1:0]   dma_addr,
   input  logic [DW-1:0]   dma_wd,
   input  logic [DW/8-1:0] dma_be,
   output logic            dma_gnt,
   output logic [DW-1:0]   dma_rd,
   output logic            dm_wr,
   output logic [AW-1:0]   dm_addr,
   output logic [DW-1:0]   dm_wd,
   output logic [DW/8-1:0] dm_be,
   input  logic [DW-1:0]   dm_rd,
   output logic [1:0]      arb_state
);

   localparam int StarveW = $clog2(STARVE_MAX + 1);

   if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
      $error("dm_port_arb: STARVE_MAX out of range 1..255");
   end
   if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst_len
      $error("dm_port_arb: BURST_LEN out of range 1..255");
   end

   typedef enum logic [1:0] {
      S_CORE  = 2'b00,
      S_FORCE = 2'b01
   } arb_state_t;

   arb_state_t         state;
   logic [StarveW-1:0] starve_cnt;
   logic               dma_owns;
   logic               stall_raw;
   logic               core_wr_ok;
   logic               dma_sel;

`ifdef DM_ARB_BURST_EN
   localparam int BeatW = $clog2(BURST_LEN + 1);
   logic [BeatW-1:0] beat_cnt;
`endif

   // Ownership and stall depend only on state and the two req lines, so the
   // M-stage address/data can never loop back into core_stall.
   always_comb begin
      dma_owns  = 1'b0;
      stall_raw = 1'b0;
      case (state)
         S_CORE:  dma_owns = !core_req && dma_req;
         S_FORCE: begin
            dma_owns  = dma_req;
            stall_raw = dma_req && core_req;
         end
         default: ;
      endcase
   end

   assign core_wr_ok = (state == S_CORE || state == S_FORCE) && core_req && core_wr && !dma_owns;
   assign dma_sel    = rst_n && dma_owns;

   assign dm_wr      = rst_n && (dma_owns ? dma_wr : core_wr_ok);
   assign dma_gnt    = dma_sel;
   assign core_stall = rst_n && stall_raw;
   assign dm_addr    = dma_sel ? dma_addr : core_addr;
   assign dm_wd      = dma_sel ? dma_wd   : core_wd;
   assign dm_be      = dma_sel ? dma_be   : core_be;
   assign core_rd    = dm_rd;
   assign dma_rd     = dm_rd;
   assign arb_state  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_CORE;
         starve_cnt <= '0;
`ifdef DM_ARB_BURST_EN
         beat_cnt   <= '0;
`endif
      end else begin
         case (state)
            S_CORE: begin
               if (core_req && dma_req) begin
                  if (starve_cnt == StarveW'(STARVE_MAX - 1)) begin
                     state      <= S_FORCE;
                     starve_cnt <= '0;
`ifdef DM_ARB_BURST_EN
                     beat_cnt   <= '0;
`endif
                  end else begin
                     starve_cnt <= starve_cnt + StarveW'(1);
                  end
               end else begin
                  starve_cnt <= '0;
               end
            end
            S_FORCE: begin
               starve_cnt <= '0;
`ifdef DM_ARB_BURST_EN
               // Burst ends on the last allowed beat or on the first idle DMA cycle.
               if (dma_req && beat_cnt != BeatW'(BURST_LEN - 1)) begin
                  beat_cnt <= beat_cnt + BeatW'(1);
               end else begin
                  state <= S_CORE;
               end
`else
               state <= S_CORE;
`endif
            end
            default: begin
               state      <= S_CORE;
               starve_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_port_arb.sv
// Self-checking bench for dm_port_arb: per-cycle expectations go through a scoreboard queue
// popped on the falling edge; a small word memory stands in for the DM.
module tb_dm_port_arb;

`ifdef DM_ARB_BURST_EN
   localparam int ForceBeats = 4;
`else
   localparam int ForceBeats = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_req, core_wr, dma_req, dma_wr;
   logic [31:0] core_addr, core_wd, dma_addr, dma_wd;
   logic [3:0]  core_be, dma_be;
   logic [31:0] core_rd, dma_rd;
   logic        core_stall, dma_gnt, dm_wr;
   logic [31:0] dm_addr, dm_wd, dm_rd;
   logic [3:0]  dm_be;
   logic [1:0]  arb_state;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      string       tag;
      logic        gnt;
      logic        stall;
      logic        wr;
      logic [1:0]  st;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        chkRd;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];

   logic [31:0] mem [0:255] = '{default: '0};
   logic        inRange;

   always #5 clk = ~clk;

   dm_port_arb #(.AW(32), .DW(32), .STARVE_MAX(4), .BURST_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_wr(core_wr), .core_addr(core_addr), .core_wd(core_wd),
      .core_be(core_be), .core_rd(core_rd), .core_stall(core_stall),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wd(dma_wd),
      .dma_be(dma_be), .dma_gnt(dma_gnt), .dma_rd(dma_rd),
      .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_be(dm_be), .dm_rd(dm_rd),
      .arb_state(arb_state)
   );

   // Word-addressed DM model: combinational read, byte-enabled write on the rising edge.
   assign inRange = (dm_addr[31:10] == 22'd0) && (dm_addr[1:0] == 2'd0);
   assign dm_rd   = inRange ? mem[dm_addr[9:2]] : 32'd0;

   always @(posedge clk) begin
      if (dm_wr && inRange) begin
         for (int b = 0; b < 4; b++) begin
            if (dm_be[b]) mem[dm_addr[9:2]][8*b +: 8] <= dm_wd[8*b +: 8];
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   // Scoreboard consumer: compares the oldest expectation against the DUT mid-cycle.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         checkOutput({e.tag, "_gnt"},   {31'd0, dma_gnt},    {31'd0, e.gnt});
         checkOutput({e.tag, "_stall"}, {31'd0, core_stall}, {31'd0, e.stall});
         checkOutput({e.tag, "_wr"},    {31'd0, dm_wr},      {31'd0, e.wr});
         checkOutput({e.tag, "_state"}, {30'd0, arb_state},  {30'd0, e.st});
         checkOutput({e.tag, "_addr"},  dm_addr, e.addr);
         checkOutput({e.tag, "_wd"},    dm_wd,   e.wd);
         if (e.chkRd) checkOutput({e.tag, "_rd"}, e.gnt ? dma_rd : core_rd, e.rd);
      end
   end

   task automatic applyStimulus(input string tag,
                                input logic creq, input logic cwr, input logic [31:0] caddr, input logic [31:0] cwd,
                                input logic dreq, input logic dwr, input logic [31:0] daddr, input logic [31:0] dwd,
                                input logic egnt, input logic estall, input logic ewr, input logic [1:0] est,
                                input logic chkRd = 1'b0, input logic [31:0] erd = 32'd0);
      exp_t e;
      @(posedge clk);
      #1;
      core_req = creq; core_wr = cwr; core_addr = caddr; core_wd = cwd;
      dma_req  = dreq; dma_wr  = dwr; dma_addr  = daddr; dma_wd  = dwd;
      e.tag   = tag;
      e.gnt   = egnt;
      e.stall = estall;
      e.wr    = ewr;
      e.st    = est;
      e.addr  = egnt ? daddr : caddr;
      e.wd    = egnt ? dwd : cwd;
      e.chkRd = chkRd;
      e.rd    = erd;
      sb.push_back(e);
   endtask

   task automatic checkMem(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      @(negedge clk);
      checkOutput(tag, mem[addr[9:2]], exp);
   endtask

   initial begin
      rst_n = 1'b0;
      core_req = 1'b1; core_wr = 1'b1; core_addr = 32'h80; core_wd = 32'hAAAA_AAAA; core_be = 4'hF;
      dma_req  = 1'b1; dma_wr  = 1'b1; dma_addr  = 32'h84; dma_wd  = 32'hBBBB_BBBB; dma_be  = 4'hF;

      repeat (2) applyStimulus("reset", 1, 1, 32'h80, 32'hAAAA_AAAA, 1, 1, 32'h84, 32'hBBBB_BBBB, 0, 0, 0, 2'b00);
      @(negedge clk);
      #2;
      core_req = 1'b0; dma_req = 1'b0;
      rst_n = 1'b1;

      applyStimulus("dmawr", 0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF, 1, 0, 1, 2'b00);
      applyStimulus("corerd", 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 2'b00, 1, 32'hDEAD_BEEF);
      applyStimulus("dmard", 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0, 1, 0, 0, 2'b00, 1, 32'hDEAD_BEEF);
      applyStimulus("idle", 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 2'b00);

      // Starvation with both requests held.
      for (int i = 0; i < 4; i++)
         applyStimulus("denied", 1, 0, 32'h100, 32'h0, 1, 0, 32'h104, 32'h0, 0, 0, 0, 2'b00);
      for (int i = 0; i < ForceBeats; i++)
         applyStimulus("forced", 1, 0, 32'h100, 32'h0, 1, 0, 32'h104, 32'h0, 1, 1, 0, 2'b01);
      applyStimulus("release", 1, 0, 32'h100, 32'h0, 1, 0, 32'h104, 32'h0, 0, 0, 0, 2'b00);
      applyStimulus("idle2", 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 2'b00);

      // DMA withdraws on the forced cycle; the core store goes through.
      for (int i = 0; i < 4; i++)
         applyStimulus("predraw", 1, 0, 32'h100, 32'h0, 1, 0, 32'h104, 32'h0, 0, 0, 0, 2'b00);
      applyStimulus("withdraw", 1, 1, 32'h20, 32'hCAFE_0020, 0, 0, 32'h104, 32'h0, 0, 0, 1, 2'b01);
      applyStimulus("postdraw", 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 2'b00);
      checkMem("mem20", 32'h20, 32'hCAFE_0020);

      // Same-address store collision: DMA wins the forced cycle, the held core store lands after.
      for (int i = 0; i < 4; i++)
         applyStimulus("coll_core", 1, 1, 32'h30, 32'h1111_1111, 1, 1, 32'h30, 32'h2222_2222, 0, 0, 1, 2'b00);
      applyStimulus("coll_dma", 1, 1, 32'h30, 32'h1111_1111, 1, 1, 32'h30, 32'h2222_2222, 1, 1, 1, 2'b01);
      applyStimulus("coll_retry", 1, 1, 32'h30, 32'h1111_1111, 0, 0, 32'h30, 32'h0, 0, 0, 1,
                    (ForceBeats > 1) ? 2'b01 : 2'b00);
      checkMem("mem30_dma", 32'h30, 32'h2222_2222);
      applyStimulus("idle3", 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 2'b00);
      checkMem("mem30_final", 32'h30, 32'h1111_1111);

`ifdef DM_ARB_BURST_EN
      // Forced burst of four DMA stores with the core stalled throughout.
      for (int i = 0; i < 4; i++)
         applyStimulus("bdenied", 1, 0, 32'h100, 32'h0, 1, 0, 32'h104, 32'h0, 0, 0, 0, 2'b00);
      for (int i = 0; i < 4; i++)
         applyStimulus("burst", 1, 0, 32'h100, 32'h0, 1, 1, 32'h40 + 32'(4*i), 32'h4000_0000 + 32'(i), 1, 1, 1, 2'b01);
      applyStimulus("bexit", 1, 0, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 2'b00);
      for (int i = 0; i < 4; i++)
         checkMem("memburst", 32'h40 + 32'(4*i), 32'h4000_0000 + 32'(i));
`endif

      @(negedge clk);
      #1;
      checkOutput("sb_drain", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
